// File: rtl/otp_decryptor_rx.sv
// One-time-pad receive side: buffers pre-shared keys in a FIFO, XORs each accepted
// ciphertext word with exactly one key (then zeroizes it), and emits registered plaintext.
module otp_decryptor_rx #(
    parameter int KEY_SIZE  = 16,
    parameter int KEY_DEPTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [KEY_SIZE-1:0]          key_in,
    input  logic                         key_valid,
    output logic                         key_ready,
    input  logic [KEY_SIZE-1:0]          ct_in,
    input  logic                         ct_valid,
    output logic                         ct_ready,
    output logic [KEY_SIZE-1:0]          pt_out,
    output logic                         pt_valid,
    input  logic                         pt_ready,
    output logic [$clog2(KEY_DEPTH):0]   key_level,
    output logic [CNT_WIDTH-1:0]         words_done,
    output logic                         key_underrun,
    input  logic                         clear_err
);

    localparam int PW = $clog2(KEY_DEPTH);
    localparam int LW = PW + 1;

    logic [KEY_SIZE-1:0]  key_mem_q [KEY_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [KEY_SIZE-1:0]  pt_q, pt_d;
    logic                 pt_vld_q, pt_vld_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 und_q, und_d;
    logic                 push, fire;

    // Full blocks a push even when a pop happens in the same cycle.
    assign key_ready = (level_q != LW'(KEY_DEPTH));
    assign ct_ready  = (level_q != '0) && (!pt_vld_q || pt_ready);
    assign push      = key_valid && key_ready;
    assign fire      = ct_valid && ct_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pt_d     = pt_q;
        pt_vld_d = pt_vld_q;
        cnt_d    = cnt_q;
        und_d    = und_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (fire) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (fire) begin
            pt_d     = ct_in ^ key_mem_q[rd_ptr_q];
            pt_vld_d = 1'b1;
        end else if (pt_ready) begin
            pt_vld_d = 1'b0;
        end

        if (fire && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);

        // A fresh underrun outranks a clear in the same cycle.
        if (ct_valid && (level_q == '0)) und_d = 1'b1;
        else if (clear_err)              und_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_DEPTH; i++) key_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pt_q     <= '0;
            pt_vld_q <= 1'b0;
            cnt_q    <= '0;
            und_q    <= 1'b0;
        end else begin
            // Slots for push and pop never coincide: equal pointers mean empty or full.
            if (fire) key_mem_q[rd_ptr_q] <= '0;
            if (push) key_mem_q[wr_ptr_q] <= key_in;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pt_q     <= pt_d;
            pt_vld_q <= pt_vld_d;
            cnt_q    <= cnt_d;
            und_q    <= und_d;
        end
    end

    assign pt_out       = pt_q;
    assign pt_valid     = pt_vld_q;
    assign key_level    = level_q;
    assign words_done   = cnt_q;
    assign key_underrun = und_q;

endmodule

// File: tb/tb_otp_decryptor_rx.sv
// Directed bench for otp_decryptor_rx: expected plaintext goes into a scoreboard queue
// at issue time and a negedge monitor pops it on every output handshake.
module tb_otp_decryptor_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] ct_in;
    logic        ct_valid;
    logic        ct_ready;
    logic [15:0] pt_out;
    logic        pt_valid;
    logic        pt_ready;
    logic [3:0]  key_level;
    logic [15:0] words_done;
    logic        key_underrun;
    logic        clear_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb[$];
    logic [15:0] kq[$];
    logic [15:0] mon_exp;
    int          nfire = 0;

    otp_decryptor_rx #(.KEY_SIZE(16), .KEY_DEPTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .ct_in(ct_in), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .pt_out(pt_out), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .key_level(key_level), .words_done(words_done),
        .key_underrun(key_underrun), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Output monitor: a handshake seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && pt_valid && pt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pt_unexpected actual=%h required=<none>", pt_out);
            end else begin
                mon_exp = sb.pop_front();
                if (pt_out !== mon_exp) begin
                    failures++;
                    $display("FAIL pt_out actual=%h required=%h", pt_out, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one ciphertext word that the bench knows will fire; records the expected plaintext.
    task automatic fire_ct(input logic [15:0] ct);
        ct_in    = ct;
        ct_valid = 1'b1;
        sb.push_back(ct ^ kq.pop_front());
        nfire++;
    endtask

    task automatic push_key(input logic [15:0] k);
        key_in    = k;
        key_valid = 1'b1;
        kq.push_back(k);
    endtask

    initial begin
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; ct_in = '0; ct_valid = 1'b0;
        pt_ready = 1'b1; clear_err = 1'b0;
        step(); step();
        chk("rst_key_level", 32'(key_level), 0);
        chk("rst_pt_valid", 32'(pt_valid), 0);
        chk("rst_pt_out", 32'(pt_out), 0);
        chk("rst_words_done", 32'(words_done), 0);
        chk("rst_underrun", 32'(key_underrun), 0);
        chk("rst_key_ready", 32'(key_ready), 1);
        rst_n = 1'b1;
        step();
        chk("empty_ct_ready", 32'(ct_ready), 0);

        // 1: single key, single word
        push_key(16'hFFFF);
        step();
        key_valid = 1'b0;
        chk("t1_ct_ready", 32'(ct_ready), 1);
        fire_ct(16'h0000);
        step();
        ct_valid = 1'b0;
        chk("t1_pt_valid", 32'(pt_valid), 1);
        chk("t1_words_done", 32'(words_done), 1);
        chk("t1_key_level", 32'(key_level), 0);
        step();
        chk("t1_pt_valid_clr", 32'(pt_valid), 0);

        // 2: two keys, back-to-back words
        push_key(16'h5555); step();
        push_key(16'h5555); step();
        key_valid = 1'b0;
        chk("t2_level2", 32'(key_level), 2);
        fire_ct(16'hAAAA); step();
        chk("t2_level1", 32'(key_level), 1);
        chk("t2_pt_ffff", 32'(pt_out), 32'h0000FFFF);
        fire_ct(16'hFFFF); step();
        ct_valid = 1'b0;
        chk("t2_level0", 32'(key_level), 0);
        chk("t2_pt_aaaa", 32'(pt_out), 32'h0000AAAA);
        chk("t2_slot1_zero", 32'(dut.key_mem_q[1]), 0);
        chk("t2_slot2_zero", 32'(dut.key_mem_q[2]), 0);
        step();

        // 3: underrun set, set-beats-clear, clear
        ct_in = 16'h1234; ct_valid = 1'b1;
        #1 chk("t3_ct_ready", 32'(ct_ready), 0);
        step();
        chk("t3_underrun_set", 32'(key_underrun), 1);
        step();
        chk("t3_underrun_sticky", 32'(key_underrun), 1);
        clear_err = 1'b1;
        step();
        chk("t3_set_wins", 32'(key_underrun), 1);
        ct_valid = 1'b0;
        step();
        chk("t3_cleared", 32'(key_underrun), 0);
        clear_err = 1'b0;
        chk("t3_words_done", 32'(words_done), 32'(nfire));

        // 4: fill, pop while full rejects push, then wrap
        for (int i = 0; i < 8; i++) begin
            push_key(16'h1000 + 16'(i) * 16'h0111);
            step();
        end
        key_valid = 1'b0;
        chk("t4_full_ready", 32'(key_ready), 0);
        chk("t4_full_level", 32'(key_level), 8);
        key_in = 16'hABCD; key_valid = 1'b1;
        fire_ct(16'h0000);
        step();
        chk("t4_push_blocked_level", 32'(key_level), 7);
        for (int i = 0; i < 10; i++) begin
            push_key(16'hC000 ^ 16'(i * 16'h0123));
            fire_ct(16'h0F0F ^ 16'(i));
            step();
        end
        key_valid = 1'b0; ct_valid = 1'b0;
        chk("t4_wrap_level", 32'(key_level), 32'(kq.size()));
        chk("t4_words_done", 32'(words_done), 32'(nfire));
        step();

        // 5: backpressure holds output, release drains and accepts same cycle
        pt_ready = 1'b0;
        fire_ct(16'h3333);
        step();
        ct_in = 16'h4444; ct_valid = 1'b1;
        #1 chk("t5_ct_ready_blocked", 32'(ct_ready), 0);
        chk("t5_pt_valid", 32'(pt_valid), 1);
        step();
        chk("t5_pt_held", 32'(pt_out), 32'(sb[0]));
        chk("t5_level_held", 32'(key_level), 32'(kq.size()));
        pt_ready = 1'b1;
        #1 chk("t5_ct_ready_released", 32'(ct_ready), 1);
        fire_ct(16'h4444);
        step();
        ct_valid = 1'b0;
        chk("t5_level_after", 32'(key_level), 32'(kq.size()));
        chk("t5_pt_next", 32'(pt_out), 32'(sb[0]));
        step();

        // 6: reset with keys and a pending word discards everything
        pt_ready = 1'b0;
        fire_ct(16'h7777);
        step();
        ct_valid = 1'b0;
        chk("t6_pending", 32'(pt_valid), 1);
        rst_n = 1'b0;
        step();
        sb.delete(); kq.delete(); nfire = 0;
        chk("t6_key_level", 32'(key_level), 0);
        chk("t6_pt_valid", 32'(pt_valid), 0);
        chk("t6_words_done", 32'(words_done), 0);
        chk("t6_key_ready", 32'(key_ready), 1);
        rst_n = 1'b1; pt_ready = 1'b1;
        step(); step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
